// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared state encoding and Booth recoding pair constants
// for the sequential radix-2 Booth multiplier.
`default_nettype none

package booth_mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_e;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/booth_mul_step.sv
// booth_step: one combinational radix-2 Booth iteration (add/sub of the
// multiplicand, then arithmetic right shift of {acc,mq}).
`default_nettype none

module booth_step
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH:0]   mq_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH:0]   mq_o,
  output logic             op_nonzero_o
);

  logic [WIDTH:0] mcand_x;
  logic [WIDTH:0] sum;

  assign mcand_x = {mcand_i[WIDTH-1], mcand_i};

  always_comb begin
    sum          = acc_i;
    op_nonzero_o = 1'b0;
    case (mq_i[1:0])
      BOOTH_ADD: begin
        sum          = acc_i + mcand_x;
        op_nonzero_o = 1'b1;
      end
      BOOTH_SUB: begin
        sum          = acc_i - mcand_x;
        op_nonzero_o = 1'b1;
      end
      BOOTH_NOP0, BOOTH_NOP1: sum = acc_i;
    endcase
  end

  // Arithmetic shift: sign bit of the widened accumulator is replicated.
  assign {acc_o, mq_o} = {sum[WIDTH], sum, mq_i[WIDTH:1]};

endmodule

`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: WIDTH-bit signed sequential Booth multiplier with
// start/ready/done handshake. Optional step counter: SEQ_MUL_STEP_COUNT_EN.
`default_nettype none

module booth_seq_multiplier
  import booth_mul_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef SEQ_MUL_STEP_COUNT_EN
  ,
  output logic [CW-1:0]        nz_steps
`endif
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH:0]     mq_q, mq_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     step_acc;
  logic [WIDTH:0]     step_mq;
  logic               step_nz;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i        (acc_q),
    .mq_i         (mq_q),
    .mcand_i      (mcand_q),
    .acc_o        (step_acc),
    .mq_o         (step_mq),
    .op_nonzero_o (step_nz)
  );

`ifdef SEQ_MUL_STEP_COUNT_EN
  logic [CW-1:0] nz_q, nz_d;

  always_comb begin
    nz_d = nz_q;
    if (state_q == IDLE && start) begin
      nz_d = '0;
    end else if (state_q == CALC && step_nz) begin
      nz_d = nz_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) nz_q <= '0;
    else       nz_q <= nz_d;
  end

  assign nz_steps = nz_q;
`else
  logic step_nz_unused;
  assign step_nz_unused = step_nz;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = '0;
          mq_d    = {b, 1'b0};
          count_d = CW'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = step_acc;
        mq_d    = step_mq;
        count_d = count_q - CW'(1);
        // Final step: capture the product from the just-computed shift result.
        if (count_q == CW'(1)) begin
          product_d = {step_acc[WIDTH-1:0], step_mq[WIDTH:1]};
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

`default_nettype wire
